// File: rtl/memory_access_pkg.sv
// rtl/memory_access_pkg.sv - shared constants, types and helpers for the MEM stage
package memory_access_pkg;

   // funct3 access size / signedness encodings
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // width of the bus timeout counter
   localparam int CNT_W = 8;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   typedef struct packed {
      logic [3:0]  strb;
      logic [31:0] data;
   } store_lane_t;

   // funct3 values that name a real access for loads or for stores
   function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
      if (is_store)
         return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

   // natural alignment check; funct3[1:0] carries the access size
   function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] lo);
      case (f3[1:0])
         2'b00:   return 1'b1;
         2'b01:   return ~lo[0];
         2'b10:   return (lo == 2'b00);
         default: return 1'b0;
      endcase
   endfunction

   // replicate store data across byte lanes and select the enabled lanes
   function automatic store_lane_t store_format(input logic [2:0] f3, input logic [1:0] lo,
                                                input logic [31:0] d);
      store_lane_t s;
      case (f3)
         F3_B: begin
            s.data = {4{d[7:0]}};
            s.strb = 4'b0001 << lo;
         end
         F3_H: begin
            s.data = {2{d[15:0]}};
            s.strb = 4'b0011 << lo;
         end
         default: begin
            s.data = d;
            s.strb = 4'b1111;
         end
      endcase
      return s;
   endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - extract and extend a load lane from a 32-bit read word
import memory_access_pkg::*;

module mem_load_align (
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // select the addressed lane, then sign- or zero-extend by funct3
   always_comb begin
      case (addr_lo)
         2'd0:    byte_lane = rdata[7:0];
         2'd1:    byte_lane = rdata[15:8];
         2'd2:    byte_lane = rdata[23:16];
         default: byte_lane = rdata[31:24];
      endcase
      half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         F3_B:    data = {{24{byte_lane[7]}}, byte_lane};
         F3_H:    data = {{16{half_lane[15]}}, half_lane};
         F3_W:    data = rdata;
         F3_BU:   data = {24'h0, byte_lane};
         F3_HU:   data = {16'h0, half_lane};
         default: data = 32'h0;
      endcase
   end

endmodule

// File: rtl/memory_access.sv
// rtl/memory_access.sv - pipeline MEM stage: bus access, store alignment, load extraction
import memory_access_pkg::*;

module memory_access #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [31:0] alu_result,
   input  logic [31:0] store_data,
   input  logic [2:0]  funct3,
   input  logic        in_MemRead,
   input  logic        in_MemWrite,
   input  logic        in_RegWrite,
   input  logic        in_MemToReg,
   input  logic [4:0]  in_RegDest,
   output logic        stop_behind,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        wb_valid,
   output logic        out_RegWrite,
   output logic        out_MemToReg,
   output logic [4:0]  out_RegDest,
   output logic [31:0] alu_result_out,
   output logic [31:0] mem_data,
   output logic        misalign_err,
   output logic        bus_err
);

   // count value on the last allowed ACCESS cycle
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;

   // instruction captured for the outstanding access
   logic [31:0] alu_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic        we_q;
   logic [2:0]  f3_q;
   logic        regwrite_q;
   logic        memtoreg_q;
   logic [4:0]  regdest_q;

   logic        is_mem_op;
   logic        req_ok;
   logic        capture;
   logic        retire_done;
   logic        retire_timeout;
   logic [31:0] load_data;
   store_lane_t lane;

   assign is_mem_op = in_MemRead | in_MemWrite;
   assign req_ok    = f3_legal(funct3, in_MemWrite) & addr_aligned(funct3, alu_result[1:0]);
   assign lane      = store_format(funct3, alu_result[1:0], store_data);

   // bus and stall outputs follow the state so reset drops them at once
   assign mem_req     = (state == ST_ACCESS);
   assign stop_behind = (state == ST_ACCESS);
   assign mem_we      = mem_req & we_q;
   assign mem_addr    = mem_req ? {alu_q[31:2], 2'b00} : 32'h0;
   assign mem_wdata   = mem_we ? wdata_q : 32'h0;
   assign mem_wstrb   = mem_we ? wstrb_q : 4'h0;

   mem_load_align u_load_align (
      .funct3  (f3_q),
      .addr_lo (alu_q[1:0]),
      .rdata   (mem_rdata),
      .data    (load_data)
   );

   // state and timeout counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // next state, counter and retire strobes; a ready on the timeout edge wins
   always_comb begin
      state_nx       = state;
      cnt_nx         = cnt;
      capture        = 1'b0;
      retire_done    = 1'b0;
      retire_timeout = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_nx = '0;
            if (enable) begin
               capture = 1'b1;
               if (is_mem_op && req_ok)
                  state_nx = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            cnt_nx = cnt + 1'b1;
            if (mem_ready) begin
               retire_done = 1'b1;
               state_nx    = ST_IDLE;
               cnt_nx      = '0;
            end else if (cnt == CNT_LAST) begin
               retire_timeout = 1'b1;
               state_nx       = ST_IDLE;
               cnt_nx         = '0;
            end
         end
         default: begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   // capture the incoming instruction and hold it for the access
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_q      <= 32'h0;
         wdata_q    <= 32'h0;
         wstrb_q    <= 4'h0;
         we_q       <= 1'b0;
         f3_q       <= 3'h0;
         regwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         regdest_q  <= 5'h0;
      end else if (capture) begin
         alu_q      <= alu_result;
         wdata_q    <= lane.data;
         wstrb_q    <= lane.strb;
         we_q       <= in_MemWrite;
         f3_q       <= funct3;
         regwrite_q <= in_RegWrite;
         memtoreg_q <= in_MemToReg;
         regdest_q  <= in_RegDest;
      end
   end

   // writeback register: one wb_valid pulse per retired entry, errors ride along
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid       <= 1'b0;
         out_RegWrite   <= 1'b0;
         out_MemToReg   <= 1'b0;
         out_RegDest    <= 5'h0;
         alu_result_out <= 32'h0;
         mem_data       <= 32'h0;
         misalign_err   <= 1'b0;
         bus_err        <= 1'b0;
      end else begin
         wb_valid     <= 1'b0;
         misalign_err <= 1'b0;
         bus_err      <= 1'b0;
         if (capture && !(is_mem_op && req_ok)) begin
            wb_valid       <= 1'b1;
            out_RegWrite   <= in_RegWrite & ~is_mem_op;
            out_MemToReg   <= in_MemToReg;
            out_RegDest    <= in_RegDest;
            alu_result_out <= alu_result;
            mem_data       <= 32'h0;
            misalign_err   <= is_mem_op;
         end
         if (retire_done || retire_timeout) begin
            wb_valid       <= 1'b1;
            out_RegWrite   <= regwrite_q & ~we_q & retire_done;
            out_MemToReg   <= memtoreg_q;
            out_RegDest    <= regdest_q;
            alu_result_out <= alu_q;
            mem_data       <= (retire_done && !we_q) ? load_data : 32'h0;
            bus_err        <= retire_timeout;
         end
      end
   end

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - randomized scoreboard bench for the MEM stage
module tb_memory_access;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [31:0] alu_result, store_data;
   logic [2:0]  funct3;
   logic        in_MemRead, in_MemWrite, in_RegWrite, in_MemToReg;
   logic [4:0]  in_RegDest;
   logic        stop_behind, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        wb_valid, out_RegWrite, out_MemToReg;
   logic [4:0]  out_RegDest;
   logic [31:0] alu_result_out, mem_data;
   logic        misalign_err, bus_err;

   always #5 clk = ~clk;

   memory_access #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .alu_result(alu_result), .store_data(store_data), .funct3(funct3),
      .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite),
      .in_RegWrite(in_RegWrite), .in_MemToReg(in_MemToReg), .in_RegDest(in_RegDest),
      .stop_behind(stop_behind), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .out_RegWrite(out_RegWrite), .out_MemToReg(out_MemToReg),
      .out_RegDest(out_RegDest), .alu_result_out(alu_result_out), .mem_data(mem_data),
      .misalign_err(misalign_err), .bus_err(bus_err)
   );

   typedef struct {
      logic        rw;
      logic        mtr;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] md;
      logic        mis;
      logic        berr;
   } wb_t;

   typedef struct {
      int          lat;
      logic [31:0] rdata;
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } bus_t;

   wb_t  exp_q[$];
   bus_t bus_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic junk();
      alu_result  = $urandom;
      store_data  = $urandom;
      funct3      = 3'($urandom);
      in_MemRead  = 1'($urandom);
      in_MemWrite = 1'($urandom);
      in_RegWrite = 1'($urandom);
      in_MemToReg = 1'($urandom);
      in_RegDest  = 5'($urandom);
   endtask

   // reference model: predicts the writeback entry and bus access, then drives the instruction
   task automatic issue(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd, input logic rw,
                        input logic [4:0] rdst, input logic mtr, input int lat,
                        input logic [31:0] rdata);
      wb_t    e;
      bus_t   b;
      int     size, off, guard;
      longint v;
      bit     legal;
      e.rw = rw; e.mtr = mtr; e.rd = rdst; e.alu = addr; e.md = 0; e.mis = 0; e.berr = 0;
      if (rd_op || wr_op) begin
         legal = wr_op ? (f3 <= 3'd2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
         size  = 1 << f3[1:0];
         off   = int'(addr % 4);
         if (!legal || (addr % size) != 0) begin
            e.mis = 1; e.rw = 0;
         end else begin
            b.lat = lat; b.rdata = rdata; b.addr = addr - 32'(off); b.we = wr_op;
            b.wdata = 0; b.wstrb = 0;
            if (wr_op) begin
               e.rw = 0;
               b.wdata = (size == 1) ? 32'(sd[7:0]) * 32'h0101_0101 :
                         (size == 2) ? 32'(sd[15:0]) * 32'h0001_0001 : sd;
               b.wstrb = 4'(((1 << size) - 1) << off);
            end
            if (lat == 0) begin
               e.rw = 0; e.berr = 1;
            end else if (!wr_op) begin
               v = longint'(rdata) >> (8 * off);
               v = v & ((longint'(1) << (8 * size)) - 1);
               if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
                  v = v - (longint'(1) << (8 * size));
               e.md = v[31:0];
            end
            bus_q.push_back(b);
         end
      end
      exp_q.push_back(e);
      alu_result = addr; store_data = sd; funct3 = f3;
      in_MemRead = rd_op; in_MemWrite = wr_op; in_RegWrite = rw;
      in_MemToReg = mtr; in_RegDest = rdst; enable = 1'b1;
      @(negedge clk);
      guard = 0;
      while (stop_behind && guard < 40) begin
         junk();
         enable = 1'($urandom);
         guard++;
         @(negedge clk);
      end
      if (guard >= 40) begin
         n_vec++; n_bad++;
         $display("FAIL stall_bound: stop_behind still 1 after %0d cycles, required release", guard);
      end
      enable = 1'b0;
   endtask

   // bus responder: answers after the planned latency and checks the request it sees
   int   r_cnt;
   bus_t r_cur;
   logic r_active = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         r_active  = 1'b0;
         mem_ready = 1'b0;
         mem_rdata = 32'h0;
      end else begin
         chk("stop_behind_vs_req", 32'(stop_behind), 32'(mem_req));
         if (mem_req) begin
            if (!r_active) begin
               if (bus_q.size() == 0) begin
                  n_vec++; n_bad++;
                  $display("FAIL bus_unexpected: mem_req=1 addr %h, required no access", mem_addr);
                  r_cur.lat = 1; r_cur.rdata = 0;
               end else begin
                  r_cur = bus_q.pop_front();
                  chk("mem_addr",  mem_addr, r_cur.addr);
                  chk("mem_we",    32'(mem_we), 32'(r_cur.we));
                  chk("mem_wdata", mem_wdata, r_cur.wdata);
                  chk("mem_wstrb", 32'(mem_wstrb), 32'(r_cur.wstrb));
               end
               r_active = 1'b1;
               r_cnt    = 0;
            end
            r_cnt++;
            if (r_cnt == r_cur.lat) begin
               mem_ready = 1'b1; mem_rdata = r_cur.rdata;
            end else begin
               mem_ready = 1'b0; mem_rdata = $urandom;
            end
         end else begin
            if (r_active) begin
               chk("req_cycles", 32'(r_cnt), 32'(r_cur.lat == 0 ? TMO : r_cur.lat));
               r_active = 1'b0;
            end
            mem_ready = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
         end
      end
   end

   // writeback monitor: pops the scoreboard on every wb_valid pulse
   wb_t m_e;
   always @(negedge clk) begin
      if (rst_n) begin
         if (wb_valid) begin
            if (exp_q.size() == 0) begin
               n_vec++; n_bad++;
               $display("FAIL wb_unexpected: wb_valid=1 dest %0d, required no entry", out_RegDest);
            end else begin
               m_e = exp_q.pop_front();
               chk("out_RegWrite",   32'(out_RegWrite), 32'(m_e.rw));
               chk("out_MemToReg",   32'(out_MemToReg), 32'(m_e.mtr));
               chk("out_RegDest",    32'(out_RegDest),  32'(m_e.rd));
               chk("alu_result_out", alu_result_out,    m_e.alu);
               chk("mem_data",       mem_data,          m_e.md);
               chk("misalign_err",   32'(misalign_err), 32'(m_e.mis));
               chk("bus_err",        32'(bus_err),      32'(m_e.berr));
            end
         end else begin
            chk("err_without_wb", 32'({misalign_err, bus_err}), 32'h0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r, gap, g;
      logic [2:0]  f3;
      logic [31:0] a;
      rst_n = 1'b0; enable = 1'b0; mem_ready = 1'b0; mem_rdata = 32'h0;
      junk();
      repeat (2) @(negedge clk);
      chk("rst_ctrl", 32'({stop_behind, mem_req, mem_we, wb_valid, out_RegWrite, out_MemToReg,
                          misalign_err, bus_err, mem_wstrb, out_RegDest}), 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_alu_out", alu_result_out, 32'h0);
      chk("rst_mem_data", mem_data, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // directed cases
      issue(0, 0, 3'b000, 32'h0000_1234, 32'h0, 1, 5'd5, 0, 1, 32'h0);
      issue(1, 0, 3'b000, 32'h0000_0103, 32'h0, 1, 5'd7, 1, 3, 32'h80FF_0000);
      issue(0, 1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 1, 5'd3, 0, 2, 32'h0);
      issue(1, 0, 3'b010, 32'h0000_0101, 32'h0, 1, 5'd9, 1, 1, 32'h0);
      issue(1, 0, 3'b101, 32'h0000_0000, 32'h0, 1, 5'd4, 1, 0, 32'h0);
      issue(1, 0, 3'b000, 32'h0000_0012, 32'h0, 1, 5'd6, 1, TMO, 32'h0077_0000);
      issue(0, 1, 3'b011, 32'h0000_0010, 32'h1, 1, 5'd2, 0, 1, 32'h0);

      // reset in the middle of an unanswered LW
      bus_q.push_back('{lat: 0, rdata: 32'h0, addr: 32'h40, we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
      alu_result = 32'h40; funct3 = 3'b010; in_MemRead = 1; in_MemWrite = 0;
      in_RegWrite = 1; in_MemToReg = 1; in_RegDest = 5'd8; enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_mem_req", 32'(mem_req), 32'h0);
      chk("rst_mid_stop_behind", 32'(stop_behind), 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(1, 0, 3'b010, 32'h0000_0000, 32'h0, 1, 5'd10, 1, 2, 32'hDEAD_BEEF);

      // randomized traffic
      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 99);
         a = $urandom;
         if (r < 25) begin
            issue(0, 0, 3'($urandom), a, $urandom, 1'($urandom), 5'($urandom), 1'($urandom),
                  1, 32'h0);
         end else if (r < 65) begin
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom);
            else begin
               g = $urandom_range(0, 4);
               f3 = (g == 3) ? 3'd4 : (g == 4) ? 3'd5 : 3'(g);
            end
            issue(1, 0, f3, a, $urandom, 1'($urandom), 5'($urandom), 1'($urandom),
                  $urandom_range(0, TMO), $urandom);
         end else begin
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            issue(0, 1, f3, a, $urandom, 1'($urandom), 5'($urandom), 1'($urandom),
                  $urandom_range(0, TMO), $urandom);
         end
         gap = $urandom_range(0, 2);
         for (int k = 0; k < gap; k++) begin
            junk();
            enable = 1'b0;
            @(negedge clk);
         end
      end

      enable = 1'b0;
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
      chk("wb_queue_drained", 32'(exp_q.size()), 32'h0);
      chk("bus_queue_drained", 32'(bus_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Pipeline MEM stage; consumes execute-stage outputs (ALU result, rs2 store data, MemRead/MemWrite/RegWrite/RegDest/MemToReg).
- Drives the data-memory request/ready bus, aligns stores, and extracts/sign-extends loads.
- Registers results toward writeback and stalls upstream stages via stop_behind while an access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for mem_ready before aborting with bus_err (8-bit counter; legal range 1..255).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  stage enable; when 0 no capture, no state change
- alu_result  in  32  effective address or ALU value
- store_data  in  32  rs2 value for stores
- funct3  in  3  access size/sign
- in_MemRead, in_MemWrite, in_RegWrite, in_MemToReg  in  1 each  control from execute
- in_RegDest  in  5  destination register
- stop_behind  out  1  stall request to IF/ID/EX
- mem_req  out  1  bus request
- mem_we  out  1  1=write
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables
- mem_ready  in  1  access complete this cycle
- mem_rdata  in  32  read word, valid with mem_ready
- wb_valid  out  1  writeback entry valid
- out_RegWrite, out_MemToReg  out  1 each  forwarded controls
- out_RegDest  out  5  forwarded destination
- alu_result_out  out  32  forwarded ALU value
- mem_data  out  32  aligned/extended load data
- misalign_err, bus_err  out  1 each  single-cycle error pulses

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including mem_req and stop_behind; timeout counter 0. mem_req drops immediately when reset asserts mid-access; the access is abandoned.
- FSM has two states, IDLE and ACCESS.
- IDLE, at a posedge with enable=1:
  - Incoming fields are latched.
  - No memory op: wb_valid=1 next cycle with forwarded controls; mem_data=0. Latency 1.
  - Memory op, aligned, legal funct3: go to ACCESS; wb_valid=0.
  - Misaligned or illegal funct3: no bus access; misalign_err pulses 1 cycle; wb_valid=1 with out_RegWrite forced 0.
- Alignment rules:
  - Half-word requires addr[0]=0; word requires addr[1:0]=0.
  - Legal loads are 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores are 000, 001, 010. All other funct3 values are illegal.
- ACCESS:
  - mem_req=1, mem_we, mem_addr, mem_wdata and mem_wstrb held stable.
  - stop_behind=1 (combinational from state).
  - Counter increments each cycle.
- mem_ready=1 at a posedge in ACCESS:
  - Go to IDLE; wb_valid=1 next cycle.
  - Load: mem_data = extracted lane of mem_rdata (sign- or zero-extended per funct3).
  - Store: out_RegWrite=0.
  - The upstream instruction is captured no earlier than the following edge (one-bubble minimum).
- Timeout: counter reaches TIMEOUT_CYCLES without mem_ready → go to IDLE, bus_err pulses, wb_valid=1 with out_RegWrite=0. A mem_ready arriving on that same edge wins; no error.
- Store lane formatting:
  - SB: wdata={4{b}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{h}}, wstrb=0011<<addr[1:0].
  - SW: wstrb=1111.
- Load extraction: byte = rdata[8*addr[1:0]+:8]; half = rdata[16*addr[1]+:16].
- enable=0 while in ACCESS: the bus transaction still completes (mem_req held); only new capture is blocked.
- wb_valid is a 1-cycle pulse per retired entry.

Decomposition:
- Shared package:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State encoding (ST_IDLE, ST_ACCESS).
  - Timeout counter width.
- Sub-module mem_load_align: combinational; funct3, addr[1:0] and rdata in, 32-bit extended data out. Reused by any future cache fill path.

Test Plan:
- Non-memory op: RegWrite=1, RegDest=5, alu_result=0x1234 → wb_valid next cycle, alu_result_out=0x1234, no mem_req.
- LB at 0x103, mem_rdata=0x80FF_0000, ready after 3 cycles → mem_addr=0x100, stop_behind high 3 cycles, mem_data=0xFFFF_FF80.
- SH at 0x202, store_data=0xABCD → mem_wdata=0xABCD_ABCD, mem_wstrb=1100, mem_we=1, out_RegWrite=0.
- LW at 0x101 → misalign_err pulse, mem_req never 1, wb_valid with out_RegWrite=0.
- LHU at 0x0, mem_ready never asserted, TIMEOUT_CYCLES=4 → mem_req high 4 cycles, bus_err pulse, return to IDLE.
- rst_n low during ACCESS → mem_req and stop_behind 0 in the same cycle; after release, a fresh LW at 0x0 completes normally.
